// File: rtl/cdc_ctrl_pkg.sv
// Shared types and constants for the CDC receive frame controller.
package cdc_ctrl_pkg;

  localparam int LEN_W = 8;
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    PAYLOAD
  } cdc_ctrl_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs payload bytes into 32-bit little-endian words and registers
// the word strobe with its keep/sop/eop qualifiers.
module byte_word_packer
  import cdc_ctrl_pkg::*;
(
  input  logic                 clkIn,
  input  logic                 rstNIn,
  input  logic                 flushIn,
  input  logic                 startIn,
  input  logic                 wrEnIn,
  input  logic                 wrLastIn,
  input  logic [LEN_W-1:0]     wrByteIn,
  output logic [8*LANES-1:0]   wordOut,
  output logic [LANES-1:0]     wordKeepOut,
  output logic                 wordValidOut,
  output logic                 wordSopOut,
  output logic                 wordEopOut
);

  logic [1:0]              lane;
  logic [8*(LANES-1)-1:0]  acc;
  logic                    sopPending;
  logic [8*LANES-1:0]      asmWord;
  logic [LANES-1:0]        asmKeep;
  logic                    emit;

  // Merge the incoming byte into the partial word; lanes above the
  // current one stay zero because acc is cleared whenever a word leaves.
  always_comb begin
    asmWord = {8'h00, acc};
    asmWord[{lane, 3'b000} +: 8] = wrByteIn;
    case (lane)
      2'd0:    asmKeep = 4'b0001;
      2'd1:    asmKeep = 4'b0011;
      2'd2:    asmKeep = 4'b0111;
      default: asmKeep = 4'b1111;
    endcase
    emit = wrEnIn && ((lane == 2'd3) || wrLastIn);
  end

  // Lane/accumulator state and registered word outputs.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      lane         <= '0;
      acc          <= '0;
      sopPending   <= 1'b0;
      wordOut      <= '0;
      wordKeepOut  <= '0;
      wordValidOut <= 1'b0;
      wordSopOut   <= 1'b0;
      wordEopOut   <= 1'b0;
    end else begin
      wordValidOut <= 1'b0;
      wordSopOut   <= 1'b0;
      wordEopOut   <= 1'b0;
      if (flushIn) begin
        lane       <= '0;
        acc        <= '0;
        sopPending <= 1'b0;
      end else if (startIn) begin
        lane       <= '0;
        acc        <= '0;
        sopPending <= 1'b1;
      end else if (wrEnIn) begin
        if (emit) begin
          wordOut      <= asmWord;
          wordKeepOut  <= asmKeep;
          wordValidOut <= 1'b1;
          wordSopOut   <= sopPending;
          wordEopOut   <= wrLastIn;
          sopPending   <= 1'b0;
          acc          <= '0;
          lane         <= wrLastIn ? 2'd0 : lane + 2'd1;
        end else begin
          acc  <= asmWord[8*(LANES-1)-1:0];
          lane <= lane + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/cdc_rx_frame_ctrl.sv
// Frame sequencer behind the slow-to-fast CDC: parses length-prefixed
// frames, feeds the word packer, and resyncs the CDC on any error.
module cdc_rx_frame_ctrl
  import cdc_ctrl_pkg::*;
#(
  parameter int RESYNC_CYCLES = 16,
  parameter int MAX_LEN       = 64,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clkIn,
  input  logic                     rstNIn,
  input  logic [7:0]               byteIn,
  input  logic                     byteValidIn,
  input  logic                     byteErrIn,
  output logic                     cdcRstOut,
  output logic [31:0]              wordOut,
  output logic [3:0]               wordKeepOut,
  output logic                     wordValidOut,
  output logic                     wordSopOut,
  output logic                     wordEopOut,
  output logic                     frameDropOut,
  output logic [ERR_CNT_WIDTH-1:0] errCntOut
);

  localparam int CNT_W = $clog2(RESYNC_CYCLES + 1);

  cdc_ctrl_state_t  state, stateNext;
  logic [LEN_W-1:0] remaining, remNext;
  logic [CNT_W-1:0] resyncCnt, cntNext;
  logic             abort;
  logic             startFrame;
  logic             wrEn;
  logic             wrLast;

  // Next-state, counter updates and packer controls.
  always_comb begin
    stateNext  = state;
    remNext    = remaining;
    cntNext    = resyncCnt;
    abort      = 1'b0;
    startFrame = 1'b0;
    wrEn       = 1'b0;
    wrLast     = 1'b0;
    case (state)
      RESYNC: begin
        if (resyncCnt <= CNT_W'(1)) begin
          cntNext   = '0;
          stateNext = IDLE;
        end else begin
          cntNext = resyncCnt - CNT_W'(1);
        end
      end
      IDLE: begin
        if (byteErrIn) begin
          abort = 1'b1;
        end else if (byteValidIn) begin
          if (byteIn == '0 || byteIn > LEN_W'(MAX_LEN)) begin
            abort = 1'b1;
          end else begin
            remNext    = byteIn;
            startFrame = 1'b1;
            stateNext  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byteErrIn) begin
          abort = 1'b1;
        end else if (byteValidIn) begin
          wrEn    = 1'b1;
          wrLast  = (remaining == LEN_W'(1));
          remNext = remaining - LEN_W'(1);
          if (wrLast) begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = RESYNC;
    endcase
    if (abort) begin
      stateNext = RESYNC;
      cntNext   = CNT_W'(RESYNC_CYCLES);
    end
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state        <= RESYNC;
      remaining    <= '0;
      resyncCnt    <= CNT_W'(RESYNC_CYCLES);
      cdcRstOut    <= 1'b1;
      frameDropOut <= 1'b0;
      errCntOut    <= '0;
    end else begin
      state        <= stateNext;
      remaining    <= remNext;
      resyncCnt    <= cntNext;
      cdcRstOut    <= (stateNext == RESYNC);
      frameDropOut <= abort;
      if (abort && errCntOut != '1) begin
        errCntOut <= errCntOut + ERR_CNT_WIDTH'(1);
      end
    end
  end

  byte_word_packer uPacker (
    .clkIn        (clkIn),
    .rstNIn       (rstNIn),
    .flushIn      (abort),
    .startIn      (startFrame),
    .wrEnIn       (wrEn),
    .wrLastIn     (wrLast),
    .wrByteIn     (byteIn),
    .wordOut      (wordOut),
    .wordKeepOut  (wordKeepOut),
    .wordValidOut (wordValidOut),
    .wordSopOut   (wordSopOut),
    .wordEopOut   (wordEopOut)
  );

endmodule

// File: tb/tb_cdc_rx_frame_ctrl.sv
// Directed self-checking bench for cdc_rx_frame_ctrl.
module tb_cdc_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [7:0]  bIn;
  logic        vIn, eIn;
  logic        cdcRstOut, wordValidOut, wordSopOut, wordEopOut, frameDropOut;
  logic [31:0] wordOut;
  logic [3:0]  wordKeepOut;
  logic [15:0] errCntOut;

  logic [7:0]  b2;
  logic        v2, e2;
  logic        cdcRst2, valid2, sop2, eop2, drop2;
  logic [31:0] word2;
  logic [3:0]  keep2;
  logic [1:0]  errCnt2;

  int checks = 0;
  int failures = 0;
  logic [37:0] wq[$];
  int dropCnt = 0;

  always #2 clk = ~clk;

  cdc_rx_frame_ctrl dut (
    .clkIn(clk), .rstNIn(rstN), .byteIn(bIn), .byteValidIn(vIn), .byteErrIn(eIn),
    .cdcRstOut(cdcRstOut), .wordOut(wordOut), .wordKeepOut(wordKeepOut),
    .wordValidOut(wordValidOut), .wordSopOut(wordSopOut), .wordEopOut(wordEopOut),
    .frameDropOut(frameDropOut), .errCntOut(errCntOut)
  );

  cdc_rx_frame_ctrl #(.RESYNC_CYCLES(16), .MAX_LEN(64), .ERR_CNT_WIDTH(2)) dut2 (
    .clkIn(clk), .rstNIn(rstN), .byteIn(b2), .byteValidIn(v2), .byteErrIn(e2),
    .cdcRstOut(cdcRst2), .wordOut(word2), .wordKeepOut(keep2),
    .wordValidOut(valid2), .wordSopOut(sop2), .wordEopOut(eop2),
    .frameDropOut(drop2), .errCntOut(errCnt2)
  );

  // Capture every emitted word as {sop, eop, keep, word} and count drops.
  always @(negedge clk) begin
    if (wordValidOut) wq.push_back({wordSopOut, wordEopOut, wordKeepOut, wordOut});
    if (frameDropOut) dropCnt++;
  end

  task automatic drive(input logic [7:0] b, input logic v, input logic e);
    @(negedge clk);
    bIn = b; vIn = v; eIn = e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic waitResync(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (cdcRstOut && n < 40);
  endtask

  task automatic test_reset;
    int n;
    bIn = 0; vIn = 0; eIn = 0; b2 = 0; v2 = 0; e2 = 0;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cdcRstOut !== 1'b1) begin failures++; $display("FAIL reset_cdcRst got=%b exp=1", cdcRstOut); end
    checks++; if (wordValidOut !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", wordValidOut); end
    checks++; if (frameDropOut !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", frameDropOut); end
    checks++; if (errCntOut !== 16'd0) begin failures++; $display("FAIL reset_errCnt got=%0d exp=0", errCntOut); end
    checks++; if (wordOut !== 32'd0) begin failures++; $display("FAIL reset_word got=%h exp=0", wordOut); end
    @(negedge clk);
    rstN = 1'b1;
    waitResync(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL reset_resync_len got=%0d exp=16", n); end
    checks++; if (errCntOut !== 16'd0) begin failures++; $display("FAIL reset_exit_errCnt got=%0d exp=0", errCntOut); end
  endtask

  task automatic test_basic;
    int base;
    logic [37:0] exp [2];
    exp[0] = {1'b1, 1'b0, 4'hF, 32'h04030201};
    exp[1] = {1'b0, 1'b1, 4'h3, 32'h00000605};
    base = wq.size();
    drive(8'd6, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) drive(8'(i), 1'b1, 1'b0);
    idle(3);
    checks++; if (wq.size() - base !== 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", wq.size() - base); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wq[base + i] !== exp[i]) begin failures++; $display("FAIL basic_word%0d got=%h exp=%h", i, wq[base + i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [37:0] exp [2];
    exp[0] = {1'b1, 1'b1, 4'hF, 32'h44332211};
    exp[1] = {1'b1, 1'b1, 4'h1, 32'h000000AA};
    base = wq.size();
    drive(8'd4, 1'b1, 1'b0);
    drive(8'h11, 1'b1, 1'b0);
    drive(8'h22, 1'b1, 1'b0);
    drive(8'h33, 1'b1, 1'b0);
    drive(8'h44, 1'b1, 1'b0);
    drive(8'd1, 1'b1, 1'b0);
    drive(8'hAA, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (wordValidOut !== 1'b1 || wordOut !== 32'h000000AA) begin
      failures++; $display("FAIL b2b_latency got valid=%b word=%h exp valid=1 word=000000aa", wordValidOut, wordOut);
    end
    idle(3);
    checks++; if (wq.size() - base !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", wq.size() - base); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wq[base + i] !== exp[i]) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, wq[base + i], exp[i]); end
    end
  endtask

  task automatic test_error;
    int base, d0, n;
    logic [37:0] exp;
    exp = {1'b1, 1'b1, 4'h7, 32'h00090807};
    base = wq.size();
    d0 = dropCnt;
    drive(8'd8, 1'b1, 1'b0);
    drive(8'h01, 1'b1, 1'b0);
    drive(8'h02, 1'b1, 1'b0);
    drive(8'h03, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (frameDropOut !== 1'b1 || cdcRstOut !== 1'b1 || wordValidOut !== 1'b0) begin
      failures++; $display("FAIL err_abort got drop=%b rst=%b valid=%b exp drop=1 rst=1 valid=0", frameDropOut, cdcRstOut, wordValidOut);
    end
    n = 0;
    do begin
      @(negedge clk);
      bIn = 8'(8'h05 + n); vIn = 1'b1; eIn = (n % 3 == 0);
      @(posedge clk); #1;
      n++;
    end while (cdcRstOut && n < 40);
    checks++; if (n !== 16) begin failures++; $display("FAIL err_resync_len got=%0d exp=16", n); end
    drive(8'd3, 1'b1, 1'b0);
    drive(8'h07, 1'b1, 1'b0);
    drive(8'h08, 1'b1, 1'b0);
    drive(8'h09, 1'b1, 1'b0);
    idle(3);
    checks++; if (dropCnt - d0 !== 1) begin failures++; $display("FAIL err_drop_pulses got=%0d exp=1", dropCnt - d0); end
    checks++; if (errCntOut !== 16'd1) begin failures++; $display("FAIL err_errCnt got=%0d exp=1", errCntOut); end
    checks++; if (wq.size() - base !== 1) begin failures++; $display("FAIL err_count got=%0d exp=1", wq.size() - base); end
    checks++; if (wq[base] !== exp) begin failures++; $display("FAIL err_next_frame got=%h exp=%h", wq[base], exp); end
  endtask

  task automatic test_bad_len;
    int base, n;
    logic [37:0] exp;
    drive(8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (frameDropOut !== 1'b1) begin failures++; $display("FAIL len0_drop got=%b exp=1", frameDropOut); end
    vIn = 1'b0;
    waitResync(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL len0_resync got=%0d exp=16", n); end
    drive(8'h41, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (frameDropOut !== 1'b1) begin failures++; $display("FAIL len65_drop got=%b exp=1", frameDropOut); end
    vIn = 1'b0;
    waitResync(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL len65_resync got=%0d exp=16", n); end
    checks++; if (errCntOut !== 16'd3) begin failures++; $display("FAIL badlen_errCnt got=%0d exp=3", errCntOut); end
    base = wq.size();
    drive(8'd64, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) drive(8'(i), 1'b1, 1'b0);
    idle(3);
    checks++; if (wq.size() - base !== 16) begin failures++; $display("FAIL len64_count got=%0d exp=16", wq.size() - base); end
    for (int k = 0; k < 16; k++) begin
      exp = {(k == 0), (k == 15), 4'hF, 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      checks++;
      if (wq[base + k] !== exp) begin failures++; $display("FAIL len64_word%0d got=%h exp=%h", k, wq[base + k], exp); end
    end
  endtask

  task automatic test_saturate;
    int n;
    logic [1:0] exp;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); e2 = 1'b1;
      @(negedge clk); e2 = 1'b0;
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (cdcRst2 && n < 40);
      exp = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
      checks++; if (errCnt2 !== exp) begin failures++; $display("FAIL sat_errCnt%0d got=%0d exp=%0d", k, errCnt2, exp); end
    end
  endtask

  task automatic test_async_reset;
    int base, n;
    logic [37:0] exp;
    exp = {1'b1, 1'b1, 4'h3, 32'h0000A55A};
    drive(8'd8, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) drive(8'(i), 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if (wordValidOut !== 1'b1) begin failures++; $display("FAIL arst_pre_valid got=%b exp=1", wordValidOut); end
    rstN = 1'b0;
    vIn = 1'b0;
    #1;
    checks++; if (wordValidOut !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", wordValidOut); end
    checks++; if (wordOut !== 32'd0) begin failures++; $display("FAIL arst_word got=%h exp=0", wordOut); end
    checks++; if (wordKeepOut !== 4'd0) begin failures++; $display("FAIL arst_keep got=%h exp=0", wordKeepOut); end
    checks++; if (errCntOut !== 16'd0) begin failures++; $display("FAIL arst_errCnt got=%0d exp=0", errCntOut); end
    checks++; if (errCnt2 !== 2'd0) begin failures++; $display("FAIL arst_errCnt2 got=%0d exp=0", errCnt2); end
    checks++; if (cdcRstOut !== 1'b1) begin failures++; $display("FAIL arst_cdcRst got=%b exp=1", cdcRstOut); end
    @(negedge clk);
    rstN = 1'b1;
    waitResync(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL arst_resync got=%0d exp=16", n); end
    base = wq.size();
    drive(8'd2, 1'b1, 1'b0);
    drive(8'h5A, 1'b1, 1'b0);
    drive(8'hA5, 1'b1, 1'b0);
    idle(3);
    checks++; if (wq.size() - base !== 1) begin failures++; $display("FAIL arst_count got=%0d exp=1", wq.size() - base); end
    checks++; if (wq[base] !== exp) begin failures++; $display("FAIL arst_frame got=%h exp=%h", wq[base], exp); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_error();
    test_bad_len();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
